// File: rtl/i2s_stereo_tx.sv
// I2S stereo transmitter: free-running mclk/bclk dividers, a one-entry sample buffer and left/right shadows.
// Macro I2S_STEREO_TX_UNDERRUN_ZERO_EN: when defined, an underrun sends silence instead of repeating the last pair.
module i2s_stereo_tx #(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = 32,
  parameter int MCLK_HALF = 2,
  parameter int BCLK_HALF = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                mclk,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun,
  output logic [7:0]          underrun_cnt
);

  localparam int PW = $clog2(2 * SLOT_W);
  localparam int EW = PW + 1;
  localparam int IW = $clog2(SAMPLE_W);
  localparam int MW = $clog2(MCLK_HALF + 1);
  localparam int BW = $clog2(BCLK_HALF + 1);

  localparam logic [PW-1:0] P_LAST  = PW'(2 * SLOT_W - 1);
  localparam logic [PW-1:0] P_RIGHT = PW'(SLOT_W);
  localparam logic [EW-1:0] L_LO    = EW'(1);
  localparam logic [EW-1:0] L_TOP   = EW'(SAMPLE_W);
  localparam logic [EW-1:0] R_LO    = EW'(SLOT_W + 1);
  localparam logic [EW-1:0] R_TOP   = EW'(SLOT_W + SAMPLE_W);

  logic [MW-1:0]       mclk_cnt;
  logic [BW-1:0]       bclk_cnt;
  logic [PW-1:0]       p;
  logic [SAMPLE_W-1:0] left_sh;
  logic [SAMPLE_W-1:0] right_sh;
  logic [SAMPLE_W-1:0] buf_l;
  logic [SAMPLE_W-1:0] buf_r;
  logic                buf_valid;

  logic                mclk_tick;
  logic                bclk_tick;
  logic                bclk_fall;
  logic                frame_load;
  logic                accept;
  logic                buf_valid_nxt;
  logic [PW-1:0]       p_nxt;
  logic [EW-1:0]       p_ext;
  logic [IW-1:0]       l_idx;
  logic [IW-1:0]       r_idx;
  logic                sdata_nxt;

  assign mclk_tick  = (mclk_cnt == MW'(MCLK_HALF - 1));
  assign bclk_tick  = (bclk_cnt == BW'(BCLK_HALF - 1));
  assign bclk_fall  = bclk_tick && bclk;
  assign p_nxt      = (p == P_LAST) ? '0 : p + 1'b1;
  assign frame_load = bclk_fall && (p == P_LAST);
  assign accept     = in_valid && in_ready;
  // A pair accepted in the load cycle stays in the buffer for the next frame.
  assign buf_valid_nxt = accept | (buf_valid & ~frame_load);

  assign p_ext = {1'b0, p_nxt};
  assign l_idx = IW'(L_TOP - p_ext);
  assign r_idx = IW'(R_TOP - p_ext);

  // Data bit for the position being entered; one-bit delay after each lrclk change.
  always_comb begin
    sdata_nxt = 1'b0;
    if (p_ext >= L_LO && p_ext <= L_TOP) begin
      sdata_nxt = left_sh[l_idx];
    end else if (p_ext >= R_LO && p_ext <= R_TOP) begin
      sdata_nxt = right_sh[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mclk_cnt     <= '0;
      bclk_cnt     <= '0;
      mclk         <= 1'b0;
      bclk         <= 1'b0;
      p            <= '0;
      lrclk        <= 1'b0;
      sdata        <= 1'b0;
      left_sh      <= '0;
      right_sh     <= '0;
      buf_l        <= '0;
      buf_r        <= '0;
      buf_valid    <= 1'b0;
      in_ready     <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      mclk_cnt <= mclk_tick ? '0 : mclk_cnt + 1'b1;
      if (mclk_tick) mclk <= ~mclk;
      bclk_cnt <= bclk_tick ? '0 : bclk_cnt + 1'b1;
      if (bclk_tick) bclk <= ~bclk;

      if (bclk_fall) begin
        p     <= p_nxt;
        lrclk <= (p_nxt >= P_RIGHT);
        sdata <= sdata_nxt;
      end

      if (accept) begin
        buf_l <= left_in;
        buf_r <= right_in;
      end
      buf_valid <= buf_valid_nxt;
      in_ready  <= ~buf_valid_nxt;
      underrun  <= frame_load && !buf_valid;

      if (frame_load) begin
        if (buf_valid) begin
          left_sh  <= buf_l;
          right_sh <= buf_r;
        end else begin
          if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
`ifdef I2S_STEREO_TX_UNDERRUN_ZERO_EN
          left_sh  <= '0;
          right_sh <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Directed bench for i2s_stereo_tx: a default-parameter instance for framing/handshake and a
// small fast-framing instance for underrun counter saturation.
module tb_i2s_stereo_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef I2S_STEREO_TX_UNDERRUN_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  // default instance
  logic        a_reset, a_valid, a_ready, a_mclk, a_bclk, a_lrclk, a_sdata, a_ur;
  logic [15:0] a_left, a_right;
  logic [7:0]  a_cnt;

  i2s_stereo_tx dut_a (
    .clk(clk), .reset(a_reset), .left_in(a_left), .right_in(a_right),
    .in_valid(a_valid), .in_ready(a_ready), .mclk(a_mclk), .bclk(a_bclk),
    .lrclk(a_lrclk), .sdata(a_sdata), .underrun(a_ur), .underrun_cnt(a_cnt)
  );

  // short-frame instance: 64 clk per frame
  logic       b_reset, b_valid, b_ready, b_mclk, b_bclk, b_lrclk, b_sdata, b_ur;
  logic [7:0] b_left, b_right;
  logic [7:0] b_cnt;

  i2s_stereo_tx #(.SAMPLE_W(8), .SLOT_W(8), .MCLK_HALF(1), .BCLK_HALF(2)) dut_b (
    .clk(clk), .reset(b_reset), .left_in(b_left), .right_in(b_right),
    .in_valid(b_valid), .in_ready(b_ready), .mclk(b_mclk), .bclk(b_bclk),
    .lrclk(b_lrclk), .sdata(b_sdata), .underrun(b_ur), .underrun_cnt(b_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected event", name);
  endtask

  // observation state, advanced only by step()
  int cyc = 0, a_tp = 0, acc_cnt = 0;
  bit prev_bclk, prev_mclk, prev_lr, prev_ready;
  int mclk_rise = -1, bclk_rise = -1, lr_rise = -1;
  int mclk_per = 0, bclk_per = 0, lr_per = 0;
  bit stream_on = 1'b0;
  int stream_k = 0;
  logic [15:0] sv_l [4] = '{16'h1357, 16'hFFFF, 16'h0F0F, 16'h5555};
  logic [15:0] sv_r [4] = '{16'h2468, 16'h0000, 16'hF0F0, 16'hAAAA};

  task automatic step(output bit fell);
    @(negedge clk);
    cyc++;
    fell = 1'b0;
    if (a_valid && prev_ready) begin
      acc_cnt++;
      if (stream_on) begin
        stream_k++;
        a_left  = sv_l[stream_k % 4];
        a_right = sv_r[stream_k % 4];
      end else begin
        a_valid = 1'b0;
      end
    end
    if (a_mclk && !prev_mclk) begin
      if (mclk_rise >= 0) mclk_per = cyc - mclk_rise;
      mclk_rise = cyc;
    end
    if (a_bclk && !prev_bclk) begin
      if (bclk_rise >= 0) bclk_per = cyc - bclk_rise;
      bclk_rise = cyc;
    end
    if (a_lrclk && !prev_lr) begin
      if (lr_rise >= 0) lr_per = cyc - lr_rise;
      lr_rise = cyc;
    end
    if (prev_bclk && !a_bclk) begin
      fell = 1'b1;
      a_tp = (a_tp == 63) ? 0 : a_tp + 1;
    end
    prev_bclk  = a_bclk;
    prev_mclk  = a_mclk;
    prev_lr    = a_lrclk;
    prev_ready = a_ready;
  endtask

  task automatic step_until(input int pos, input string name);
    bit fell;
    int guard = 0;
    do begin
      step(fell);
      guard++;
    end while (!(fell && a_tp == pos) && guard < 3000);
    if (guard >= 3000) fail_now(name);
  endtask

  logic [63:0] fr_sd, fr_lr;
  int fr_ur, fr_rdy, fr_acc;

  // Records one frame from the wrap to p=63; optionally offers a pair right after the wrap.
  task automatic capture_frame(input bit do_push, input logic [15:0] pl, input logic [15:0] pr);
    bit fell;
    int guard = 0;
    int acc_w;
    step_until(0, "wrap_wait");
    fr_sd = '0;
    fr_lr = '0;
    fr_sd[0] = a_sdata;
    fr_lr[0] = a_lrclk;
    fr_ur  = int'(a_ur);
    fr_rdy = int'(a_ready);
    acc_w  = acc_cnt;
    if (do_push) begin
      a_left  = pl;
      a_right = pr;
      a_valid = 1'b1;
    end
    while (a_tp != 63 && guard < 3000) begin
      step(fell);
      guard++;
      fr_ur  += int'(a_ur);
      fr_rdy += int'(a_ready);
      if (fell) begin
        fr_sd[a_tp] = a_sdata;
        fr_lr[a_tp] = a_lrclk;
      end
    end
    if (guard >= 3000) fail_now("frame_end_wait");
    fr_acc = acc_cnt - acc_w;
    if (do_push && a_valid && !stream_on) begin
      fail_now("push_not_accepted");
      a_valid = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er,
                             input int eur, input logic [7:0] ecnt);
    logic [15:0] gl, gr;
    for (int i = 0; i < 16; i++) begin
      gl[15-i] = fr_sd[1+i];
      gr[15-i] = fr_sd[33+i];
    end
    check({tag, "_left"}, gl, el);
    check({tag, "_right"}, gr, er);
    check({tag, "_pad_zero"}, fr_sd & ~64'h0001_FFFE_0001_FFFE, 64'h0);
    check({tag, "_lrclk"}, fr_lr, 64'hFFFF_FFFF_0000_0000);
    check({tag, "_underrun"}, fr_ur, eur);
    check({tag, "_underrun_cnt"}, a_cnt, ecnt);
  endtask

  task automatic reset_a(input int hold);
    bit fell;
    int n;
    a_reset = 1'b1;
    a_valid = 1'b0;
    repeat (hold) @(negedge clk);
    check("reset_outputs", {a_ready, a_mclk, a_bclk, a_lrclk, a_sdata, a_ur, a_cnt}, 64'h0);
    a_reset = 1'b0;
    a_tp = 0;
    prev_bclk = 1'b0; prev_mclk = 1'b0; prev_lr = 1'b0; prev_ready = 1'b0;
    mclk_rise = -1; bclk_rise = -1; lr_rise = -1;
    step(fell);
    check("ready_after_reset", a_ready, 1);
    n = 1;
    while (!a_bclk && n < 100) begin
      step(fell);
      n++;
    end
    check("first_bclk_rise", n, 8);
  endtask

  function automatic logic [15:0] rep(input logic [15:0] v);
    return ZERO_EN ? 16'h0 : v;
  endfunction

  typedef struct {
    logic        push;
    logic [15:0] pl, pr;
    logic [15:0] el, er;
    int          eur;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit fell;
    int acc0, pulses, adjacent;
    bit prev_b;

    a_reset = 1'b1; a_valid = 1'b0; a_left = '0; a_right = '0;
    b_reset = 1'b1; b_valid = 1'b0; b_left = '0; b_right = '0;

    // push pair offered during the frame; expectations for that same frame
    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 16'hA5C3,      16'h0001,      0, 8'd0};
    vecs[1] = '{1'b1, 16'h1234, 16'hFEDC, rep(16'hA5C3), rep(16'h0001), 1, 8'd1};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h1234,      16'hFEDC,      0, 8'd1};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, rep(16'h1234), rep(16'hFEDC), 1, 8'd2};
    vecs[4] = '{1'b1, 16'h8000, 16'h7FFF, rep(16'h1234), rep(16'hFEDC), 1, 8'd3};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'h8000,      16'h7FFF,      0, 8'd3};

    repeat (2) @(negedge clk);
    reset_a(3);

    // pair offered before the first frame load
    a_left = 16'hA5C3; a_right = 16'h0001; a_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      capture_frame(vecs[i].push, vecs[i].pl, vecs[i].pr);
      check_frame($sformatf("vec%0d", i), vecs[i].el, vecs[i].er, vecs[i].eur, vecs[i].ecnt);
      if (i == 0) begin
        check("mclk_period", mclk_per, 4);
        check("bclk_period", bclk_per, 16);
        check("lrclk_period", lr_per, 1024);
      end
    end

    // offer a pair exactly in the load cycle of an empty-buffer frame
    repeat (15) step(fell);
    a_left = 16'h1111; a_right = 16'h2222; a_valid = 1'b1;
    acc0 = acc_cnt;
    capture_frame(1'b0, 16'h0, 16'h0);
    check_frame("loadcyc", rep(16'h8000), rep(16'h7FFF), 1, 8'd4);
    check("loadcyc_accept", acc_cnt - acc0, 1);
    check("loadcyc_ready_low", fr_rdy, 0);
    capture_frame(1'b0, 16'h0, 16'h0);
    check_frame("loadcyc_next", 16'h1111, 16'h2222, 0, 8'd4);

    // in_valid held high: one acceptance per frame, no underruns
    stream_on = 1'b1; stream_k = 0;
    a_left = sv_l[0]; a_right = sv_r[0]; a_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      capture_frame(1'b0, 16'h0, 16'h0);
      check_frame($sformatf("stream%0d", f), sv_l[f], sv_r[f], 0, 8'd4);
      check($sformatf("stream%0d_ready_cycles", f), fr_rdy, 1);
      check($sformatf("stream%0d_accepts", f), fr_acc, 1);
    end
    stream_on = 1'b0;
    a_valid = 1'b0;

    // refill after the next load, then reset mid-frame with the buffer full
    step_until(0, "refill_wrap");
    a_left = 16'h7E7E; a_right = 16'h8181; a_valid = 1'b1;
    step_until(20, "reach_p20");
    check("p20_buffer_full", a_ready, 0);
    reset_a(3);
    capture_frame(1'b0, 16'h0, 16'h0);
    check_frame("after_reset", 16'h0, 16'h0, 1, 8'd1);

    // 300 empty frames on the short-frame instance
    repeat (2) @(negedge clk);
    b_reset = 1'b0;
    pulses = 0; adjacent = 0; prev_b = 1'b0;
    for (int c = 0; c < 300 * 64 + 40; c++) begin
      @(negedge clk);
      if (b_ur) begin
        pulses++;
        if (prev_b) adjacent++;
        if (pulses == 200) check("sat_cnt_at_200", b_cnt, 200);
      end
      prev_b = b_ur;
    end
    check("sat_pulses", pulses, 300);
    check("sat_pulse_width", adjacent, 0);
    check("sat_cnt_final", b_cnt, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_stereo_tx.md
I2S_STEREO_TX -- requirements
Module: i2s_stereo_tx

Interface
REQ-001 Parameter SAMPLE_W, default 16: sample width per channel, 8..32.
REQ-002 Parameter SLOT_W, default 32: bits per channel slot; must satisfy SAMPLE_W <= SLOT_W <= 32.
REQ-003 Parameter MCLK_HALF, default 2: clk cycles per mclk half-period, >= 1.
REQ-004 Parameter BCLK_HALF, default 8: clk cycles per bclk half-period, >= 2.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 left_in  in  SAMPLE_W  left sample, signed two's complement.
REQ-008 right_in  in  SAMPLE_W  right sample, signed two's complement.
REQ-009 in_valid  in  1  sample pair valid.
REQ-010 in_ready  out  1  one-entry input buffer empty.
REQ-011 mclk  out  1  master clock.
REQ-012 bclk  out  1  bit clock.
REQ-013 lrclk  out  1  word select; 0 = left, 1 = right.
REQ-014 sdata  out  1  serial data.
REQ-015 underrun  out  1  one-cycle pulse on a frame load with an empty buffer.
REQ-016 underrun_cnt  out  8  saturating underrun count.

Function
REQ-017 mclk SHALL toggle every MCLK_HALF clk cycles, free-running and independent of bclk.
REQ-018 bclk SHALL toggle every BCLK_HALF clk cycles; a bclk falling edge is the clk cycle in which bclk goes 1->0.
REQ-019 Frame position p (0..2*SLOT_W-1) SHALL advance by 1 on every bclk falling edge and wrap from 2*SLOT_W-1 to 0.
REQ-020 lrclk, sdata and p SHALL update only on bclk falling edges.
REQ-021 lrclk SHALL be 1 for p in SLOT_W..2*SLOT_W-1, else 0.
REQ-022 For p = 1..SAMPLE_W, sdata SHALL carry left-shadow bit SAMPLE_W-p, MSB first.
REQ-023 For p = SLOT_W+1..SLOT_W+SAMPLE_W, sdata SHALL carry right-shadow bit SAMPLE_W-(p-SLOT_W).
REQ-024 At every other p, sdata SHALL be 0 (this is the standard I2S one-bit delay with zero padding).
REQ-025 Handshake: the sample pair SHALL be accepted into the buffer in a cycle where in_valid=1 and in_ready=1.
REQ-026 in_ready SHALL be registered and SHALL equal 1 exactly when the buffer is empty.
REQ-027 Frame load SHALL occur on the bclk falling edge where p wraps to 0.
REQ-028 On a frame load with the buffer full, the buffer contents SHALL be copied to the shadows and the buffer emptied; in_ready SHALL rise the next cycle.
REQ-029 On a frame load with the buffer empty: pulse underrun for 1 cycle, increment underrun_cnt saturating at 255, and select shadow contents per REQ-035.
REQ-030 Acceptance in the frame-load cycle SHALL NOT bypass to the shadows; the sample is used at the following frame load.
REQ-031 Frame period SHALL be 4*SLOT_W*BCLK_HALF clk cycles (1/fs = 3.125 MHz / 64 = 48.83 kHz at defaults with a 50 MHz clk).

Reset
REQ-032 While reset=1, the following SHALL all be 0: mclk, bclk, lrclk, sdata, underrun, underrun_cnt, p, shadows, all dividers, buffer valid, in_ready.
REQ-033 in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-034 Reset asserted mid-frame SHALL abort the frame and discard buffered data; after release, the first bclk rise SHALL occur BCLK_HALF cycles later.

Configuration
REQ-035 Macro I2S_STEREO_TX_UNDERRUN_ZERO_EN: defined, an underrun loads both shadows with 0; undefined, the shadows keep their previous sample (repeat).

Verification
REQ-036 Reset, defaults: in_ready=0 during reset and 1 next cycle; bclk period 16 clk; mclk period 4 clk; lrclk period 1024 clk.
REQ-037 Push L=16'hA5C3, R=16'h0001 before the first frame load: sdata is 0 at p=0, then 1010010111000011 at p=1..16, 0 at p=17..32, 0...01 at p=33..48, lrclk rises at p=32.
REQ-038 No pushes after one frame: underrun pulses once per frame and underrun_cnt=3 after 3 frames; with the macro defined sdata is all 0, without it the prior sample repeats.
REQ-039 Hold in_valid=1 continuously: exactly one pair is accepted per frame, in_ready is low from acceptance until the load cycle +1, and underrun is never asserted.
REQ-040 300 empty frames: underrun_cnt saturates at 255 and underrun still pulses each frame.
REQ-041 Assert reset at p=20 with the buffer full: all outputs 0, the buffer is discarded, and the next frame underruns unless a new pair is pushed.
